// File: rtl/xtea_pkg.sv
// Shared definitions for the xtea stream feeder: block geometry and control states.
package xtea_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned BLOCK_W         = 128;
    localparam int unsigned WORDS_PER_BLOCK = 4;

    typedef enum logic [1:0] {
        StFill,
        StLaunch,
        StWait,
        StDrain
    } state_e;

    // Word 0 is the most significant slice of the block.
    function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                     input logic [1:0]         idx);
        logic [WORD_W-1:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/xtea_block_feeder.sv
// Packs 32-bit words into 128-bit xtea blocks with optional CBC chaining,
// launches the core, and unpacks the result back onto the word stream.
module xtea_block_feeder
    import xtea_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enc_dec,
    input  logic               cbc_en,
    input  logic [BLOCK_W-1:0] iv,
    input  logic               iv_load,
    input  logic               in_valid,
    input  logic [WORD_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [WORD_W-1:0]  out_data,
    input  logic               out_ready,
    output logic               core_start,
    output logic               core_enc_dec,
    output logic [BLOCK_W-1:0] core_data_in,
    input  logic               core_ready,
    input  logic               core_busy,
    input  logic [BLOCK_W-1:0] core_data_out,
    output logic               err
);

    localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    state_e                      state_q, state_d;
    logic [1:0]                  count_q, count_d;
    logic [BLOCK_W-WORD_W-1:0]   block_q, block_d;
    logic                        enc_q, enc_d;
    logic                        cbc_q, cbc_d;
    logic [BLOCK_W-1:0]          chain_q, chain_d;
    logic [BLOCK_W-1:0]          core_in_q, core_in_d;
    logic [BLOCK_W-1:0]          res_q, res_d;
    logic [1:0]                  idx_q, idx_d;
    logic [TimerW-1:0]           timer_q, timer_d;
    logic                        err_q, err_d;
    logic [BLOCK_W-1:0]          full_block;

    // Busy is status only; control relies solely on core_ready.
    logic unused_core_busy;
    assign unused_core_busy = core_busy;

    assign full_block   = {block_q, in_data};
    assign core_enc_dec = enc_q;
    assign core_data_in = core_in_q;
    assign err          = err_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        block_d    = block_q;
        enc_d      = enc_q;
        cbc_d      = cbc_q;
        chain_d    = chain_q;
        core_in_d  = core_in_q;
        res_d      = res_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        err_d      = err_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        core_start = 1'b0;

        unique case (state_q)
            StFill: begin
                in_ready = 1'b1;
                if (count_q == 2'd0 && iv_load) begin
                    chain_d = iv;
                end
                if (in_valid) begin
                    count_d = count_q + 2'd1;
                    case (count_q)
                        2'd0: begin
                            block_d[95:64] = in_data;
                            enc_d          = enc_dec;
                            cbc_d          = cbc_en;
                        end
                        2'd1: block_d[63:32] = in_data;
                        2'd2: block_d[31:0]  = in_data;
                        default: begin
                            core_in_d = (enc_q && cbc_q) ? (full_block ^ chain_q) : full_block;
                            state_d   = StLaunch;
                        end
                    endcase
                end
            end

            StLaunch: begin
                core_start = 1'b1;
                timer_d    = '0;
                state_d    = StWait;
            end

            StWait: begin
                if (core_ready) begin
                    if (cbc_q && enc_q) begin
                        res_d   = core_data_out;
                        chain_d = core_data_out;
                    end else if (cbc_q) begin
                        // Next block chains on the ciphertext we just fed in.
                        res_d   = core_data_out ^ chain_q;
                        chain_d = core_in_q;
                    end else begin
                        res_d = core_data_out;
                    end
                    idx_d   = 2'd0;
                    state_d = StDrain;
                end else if (TIMEOUT_CYCLES != 0 && timer_q == TimerLast) begin
                    err_d   = 1'b1;
                    count_d = 2'd0;
                    state_d = StFill;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            StDrain: begin
                out_valid = 1'b1;
                out_data  = block_word(res_q, idx_q);
                if (out_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        count_d = 2'd0;
                        state_d = StFill;
                    end
                end
            end

            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StFill;
            count_q   <= 2'd0;
            block_q   <= '0;
            enc_q     <= 1'b1;
            cbc_q     <= 1'b0;
            chain_q   <= '0;
            core_in_q <= '0;
            res_q     <= '0;
            idx_q     <= 2'd0;
            timer_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            block_q   <= block_d;
            enc_q     <= enc_d;
            cbc_q     <= cbc_d;
            chain_q   <= chain_d;
            core_in_q <= core_in_d;
            res_q     <= res_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_xtea_block_feeder.sv
// Directed bench: two feeder instances, one with a 20-cycle core model and
// one with an 8-cycle timeout and a controllable core.
module tb_xtea_block_feeder;

    localparam logic [127:0] IV   = 128'hDEADBEEF_89ABCDEF_01234567_DEADBEEF;
    localparam logic [127:0] ONES = {4{32'hFFFFFFFF}};

    logic         clock = 1'b0;
    logic         reset_a = 1'b1, reset_b = 1'b1;
    logic         enc_dec = 1'b1, cbc_en = 1'b0, iv_load = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b1, use_b = 1'b0, en_b = 1'b0;
    logic [127:0] iv = '0;
    logic [31:0]  in_data = '0;

    logic         in_ready_a, out_valid_a, core_start_a, core_enc_dec_a, err_a, core_ready_a;
    logic         in_ready_b, out_valid_b, core_start_b, core_enc_dec_b, err_b, core_ready_b;
    logic [31:0]  out_data_a, out_data_b;
    logic [127:0] core_data_in_a, core_data_in_b, core_data_out_a, core_data_out_b;
    logic [127:0] cap_a = '0, cap_b = '0;
    int           cnt_a = 0, cnt_b = 0;
    int           checks = 0, errors = 0;

    logic         in_ready_s, out_valid_s, core_start_s;
    logic [31:0]  out_data_s;
    logic [127:0] core_data_in_s;

    always #5 clock = ~clock;

    xtea_block_feeder dut_a (
        .clock(clock), .reset(reset_a), .enc_dec(enc_dec), .cbc_en(cbc_en), .iv(iv),
        .iv_load(iv_load), .in_valid(in_valid && !use_b), .in_data(in_data),
        .in_ready(in_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
        .out_ready(out_ready), .core_start(core_start_a), .core_enc_dec(core_enc_dec_a),
        .core_data_in(core_data_in_a), .core_ready(core_ready_a), .core_busy(cnt_a != 0),
        .core_data_out(core_data_out_a), .err(err_a)
    );

    xtea_block_feeder #(.TIMEOUT_CYCLES(8)) dut_b (
        .clock(clock), .reset(reset_b), .enc_dec(enc_dec), .cbc_en(cbc_en), .iv(iv),
        .iv_load(iv_load), .in_valid(in_valid && use_b), .in_data(in_data),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
        .out_ready(out_ready), .core_start(core_start_b), .core_enc_dec(core_enc_dec_b),
        .core_data_in(core_data_in_b), .core_ready(core_ready_b), .core_busy(cnt_b != 0),
        .core_data_out(core_data_out_b), .err(err_b)
    );

    assign in_ready_s     = use_b ? in_ready_b     : in_ready_a;
    assign out_valid_s    = use_b ? out_valid_b    : out_valid_a;
    assign out_data_s     = use_b ? out_data_b     : out_data_a;
    assign core_start_s   = use_b ? core_start_b   : core_start_a;
    assign core_data_in_s = use_b ? core_data_in_b : core_data_in_a;

    // Core model: result = input inverted, ready 20 cycles (A) / 3 cycles (B) after start.
    always @(posedge clock) begin
        if (reset_a) cnt_a <= 0;
        else if (core_start_a) begin cnt_a <= 20; cap_a <= core_data_in_a; end
        else if (cnt_a > 0) cnt_a <= cnt_a - 1;
        if (reset_b) cnt_b <= 0;
        else if (core_start_b) begin cnt_b <= 3; cap_b <= core_data_in_b; end
        else if (cnt_b > 0) cnt_b <= cnt_b - 1;
    end
    assign core_ready_a    = (cnt_a == 1);
    assign core_data_out_a = cap_a ^ ONES;
    assign core_ready_b    = en_b && (cnt_b == 1);
    assign core_data_out_b = cap_b ^ ONES;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic send_word(input logic [31:0] d, input logic load);
        int n = 0;
        while (!in_ready_s && n < 200) begin tick(); n++; end
        if (!in_ready_s) begin
            checks++; errors++;
            $display("FAIL send_wait: in_ready got 0 want 1");
        end
        in_valid = 1'b1; in_data = d; iv_load = load;
        tick();
        in_valid = 1'b0; iv_load = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] blk, input logic load);
        send_word(blk[127:96], load);
        send_word(blk[95:64], 1'b0);
        send_word(blk[63:32], 1'b0);
        send_word(blk[31:0], 1'b0);
    endtask

    task automatic recv_word(output logic [31:0] d);
        int n = 0;
        while (!out_valid_s && n < 200) begin tick(); n++; end
        if (!out_valid_s) begin
            checks++; errors++;
            $display("FAIL recv_wait: out_valid got 0 want 1");
            d = 'x;
        end else begin
            d = out_data_s;
        end
        tick();
    endtask

    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1;
        tick(); tick();
        reset_a = 1'b0; reset_b = 1'b0;
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready_a); end
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid_a); end
        checks++; if (out_data_a !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data_a); end
        checks++; if (core_start_a !== 1'b0) begin errors++; $display("FAIL rst_core_start: got %b want 0", core_start_a); end
        checks++; if (core_enc_dec_a !== 1'b1) begin errors++; $display("FAIL rst_core_enc_dec: got %b want 1", core_enc_dec_a); end
        checks++; if (core_data_in_a !== 128'h0) begin errors++; $display("FAIL rst_core_data_in: got %h want 0", core_data_in_a); end
        checks++; if (err_a !== 1'b0 || err_b !== 1'b0) begin errors++; $display("FAIL rst_err: got %b%b want 00", err_a, err_b); end
    endtask

    task automatic test_ecb();
        logic [31:0] exp_w [4];
        logic [31:0] got;
        int n = 0;
        exp_w = '{32'h55554444, 32'h33332222, 32'h55554444, 32'h33332222};
        use_b = 1'b0; enc_dec = 1'b1; cbc_en = 1'b0;
        send_block(128'hAAAABBBB_CCCCDDDD_AAAABBBB_CCCCDDDD, 1'b0);
        checks++; if (core_start_a !== 1'b1) begin errors++; $display("FAIL ecb_start: got %b want 1", core_start_a); end
        checks++; if (core_data_in_a !== 128'hAAAABBBB_CCCCDDDD_AAAABBBB_CCCCDDDD) begin errors++; $display("FAIL ecb_core_in: got %h want AAAABBBBCCCCDDDDAAAABBBBCCCCDDDD", core_data_in_a); end
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL ecb_launch_in_ready: got %b want 0", in_ready_a); end
        tick();
        checks++; if (core_start_a !== 1'b0) begin errors++; $display("FAIL ecb_start_pulse: got %b want 0", core_start_a); end
        while (!core_ready_a && n < 100) begin tick(); n++; end
        checks++; if (core_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin errors++; $display("FAIL ecb_ready_cycle: ready %b out_valid %b want 1 0", core_ready_a, out_valid_a); end
        tick();
        checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL ecb_out_latency: got %b want 1", out_valid_a); end
        for (int i = 0; i < 4; i++) begin
            recv_word(got);
            checks++; if (got !== exp_w[i]) begin errors++; $display("FAIL ecb_word%0d: got %h want %h", i, got, exp_w[i]); end
        end
        checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin errors++; $display("FAIL ecb_back_to_fill: out_valid %b in_ready %b want 0 1", out_valid_a, in_ready_a); end
    endtask

    task automatic test_cbc_encrypt();
        logic [31:0] got;
        use_b = 1'b0; enc_dec = 1'b1; cbc_en = 1'b1; iv = IV;
        send_block(128'h0, 1'b1);
        checks++; if (core_data_in_a !== IV) begin errors++; $display("FAIL cbc_enc_blk1: got %h want %h", core_data_in_a, IV); end
        for (int i = 0; i < 4; i++) begin
            recv_word(got);
            checks++; if (got !== ~IV[127-32*i -: 32]) begin errors++; $display("FAIL cbc_enc_blk1_w%0d: got %h want %h", i, got, ~IV[127-32*i -: 32]); end
        end
        // iv_load mid-block must be ignored.
        send_word(32'h0, 1'b0);
        send_word(32'h0, 1'b0);
        iv = 128'h12345678_12345678_12345678_12345678;
        send_word(32'h0, 1'b1);
        send_word(32'h0, 1'b0);
        checks++; if (core_data_in_a !== ~IV) begin errors++; $display("FAIL cbc_enc_blk2: got %h want %h", core_data_in_a, ~IV); end
        for (int i = 0; i < 4; i++) begin
            recv_word(got);
            checks++; if (got !== IV[127-32*i -: 32]) begin errors++; $display("FAIL cbc_enc_blk2_w%0d: got %h want %h", i, got, IV[127-32*i -: 32]); end
        end
        iv = IV;
    endtask

    task automatic test_cbc_decrypt();
        logic [31:0] exp_w [4];
        logic [31:0] got;
        exp_w = '{32'h21524110, 32'h76543210, 32'hFEDCBA98, 32'h21524110};
        use_b = 1'b0; enc_dec = 1'b0; cbc_en = 1'b1; iv = IV;
        send_block(128'h0, 1'b1);
        checks++; if (core_data_in_a !== 128'h0 || core_enc_dec_a !== 1'b0) begin errors++; $display("FAIL cbc_dec_launch: core_in %h mode %b want 0 0", core_data_in_a, core_enc_dec_a); end
        for (int i = 0; i < 4; i++) begin
            recv_word(got);
            checks++; if (got !== exp_w[i]) begin errors++; $display("FAIL cbc_dec_w%0d: got %h want %h", i, got, exp_w[i]); end
        end
        // Chain now holds the zero ciphertext: a zero CBC encrypt block goes out unchanged.
        enc_dec = 1'b1;
        send_block(128'h0, 1'b0);
        checks++; if (core_data_in_a !== 128'h0) begin errors++; $display("FAIL cbc_dec_chain: got %h want 0", core_data_in_a); end
        for (int i = 0; i < 4; i++) begin
            recv_word(got);
            checks++; if (got !== 32'hFFFFFFFF) begin errors++; $display("FAIL cbc_dec_next_w%0d: got %h want ffffffff", i, got); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_w [4];
        logic [31:0] got;
        exp_w = '{32'hFEDCBA98, 32'h76543210, 32'hF0F0F0F0, 32'h0F0F0F0F};
        use_b = 1'b0; enc_dec = 1'b1; cbc_en = 1'b0;
        send_block(128'h01234567_89ABCDEF_0F0F0F0F_F0F0F0F0, 1'b0);
        recv_word(got);
        checks++; if (got !== exp_w[0]) begin errors++; $display("FAIL bp_word0: got %h want %h", got, exp_w[0]); end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid_a !== 1'b1 || out_data_a !== exp_w[1] || in_ready_a !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid %b data %h in_ready %b want 1 %h 0", i, out_valid_a, out_data_a, in_ready_a, exp_w[1]);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            recv_word(got);
            checks++; if (got !== exp_w[i]) begin errors++; $display("FAIL bp_word%0d: got %h want %h", i, got, exp_w[i]); end
        end
    endtask

    task automatic test_reset_mid_block();
        logic [31:0] exp_w [4];
        logic [31:0] got;
        exp_w = '{32'hEEEEEEEE, 32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB};
        use_b = 1'b0; enc_dec = 1'b1; cbc_en = 1'b1;
        send_word(32'hAAAAAAAA, 1'b0);
        send_word(32'h55555555, 1'b0);
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin errors++; $display("FAIL midrst_flags: in_ready %b out_valid %b want 1 0", in_ready_a, out_valid_a); end
        // Chain was all-ones before reset; a zero chain passes the block through.
        send_block(128'h11111111_22222222_33333333_44444444, 1'b0);
        checks++; if (core_data_in_a !== 128'h11111111_22222222_33333333_44444444) begin errors++; $display("FAIL midrst_core_in: got %h want 11111111222222223333333344444444", core_data_in_a); end
        for (int i = 0; i < 4; i++) begin
            recv_word(got);
            checks++; if (got !== exp_w[i]) begin errors++; $display("FAIL midrst_w%0d: got %h want %h", i, got, exp_w[i]); end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] exp_w [4];
        logic [31:0] got;
        exp_w = '{32'hEEEEEEEE, 32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB};
        use_b = 1'b1; en_b = 1'b0; enc_dec = 1'b1; cbc_en = 1'b0;
        reset_b = 1'b1;
        tick();
        reset_b = 1'b0;
        send_block(128'h01020304_05060708_090A0B0C_0D0E0F10, 1'b0);
        checks++; if (core_start_s !== 1'b1) begin errors++; $display("FAIL to_start: got %b want 1", core_start_s); end
        repeat (8) tick();
        checks++; if (err_b !== 1'b0 || in_ready_b !== 1'b0) begin errors++; $display("FAIL to_early: err %b in_ready %b want 0 0", err_b, in_ready_b); end
        tick();
        checks++; if (err_b !== 1'b1 || in_ready_b !== 1'b1) begin errors++; $display("FAIL to_abort: err %b in_ready %b want 1 1", err_b, in_ready_b); end
        en_b = 1'b1;
        send_block(128'h11111111_22222222_33333333_44444444, 1'b0);
        checks++; if (core_data_in_s !== 128'h11111111_22222222_33333333_44444444) begin errors++; $display("FAIL to_next_core_in: got %h want 11111111222222223333333344444444", core_data_in_s); end
        for (int i = 0; i < 4; i++) begin
            recv_word(got);
            checks++; if (got !== exp_w[i]) begin errors++; $display("FAIL to_next_w%0d: got %h want %h", i, got, exp_w[i]); end
        end
        checks++; if (err_b !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", err_b); end
        use_b = 1'b0;
    endtask

    initial begin
        tick();
        test_reset();
        test_ecb();
        test_cbc_encrypt();
        test_cbc_decrypt();
        test_backpressure();
        test_reset_mid_block();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/xtea_block_feeder.md
Name: xtea_block_feeder

Overview:
- Stream front/back-end for the xtea core.
- Packs 32-bit input words into a 128-bit block and optionally applies CBC chaining.
- Launches the core with a one-cycle start pulse and waits for the core's ready.
- Unpacks the 128-bit result into four 32-bit output words; sits between the system word bus and the xtea core (key is wired to the core directly).

Parameters:
TIMEOUT_CYCLES, 1023, max cycles in WAIT for core_ready before aborting; 0 disables the timeout.

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
enc_dec  input  1  1=encrypt, 0=decrypt; sampled with first word of each block
cbc_en  input  1  1=CBC chaining, 0=ECB; sampled with first word of each block
iv  input  128  initialisation vector
iv_load  input  1  loads iv into chain register (honoured only in FILL with word count 0)
in_valid  input  1  input word valid
in_data  input  32  input word
in_ready  output  1  feeder accepts a word
out_valid  output  1  output word valid
out_data  output  32  output word
out_ready  input  1  downstream accepts a word
core_start  output  1  one-cycle start pulse to xtea
core_enc_dec  output  1  mode to xtea; registered, held stable
core_data_in  output  128  block to xtea; registered, held stable until next launch
core_ready  input  1  xtea result valid
core_busy  input  1  xtea busy (status only)
core_data_out  input  128  xtea result
err  output  1  sticky timeout flag

Behaviour:
- Reset (sync, active-high):
  - State=FILL, word count=0, chain=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, core_start=0, core_enc_dec=1, core_data_in=0, err=0.
  - Reset mid-operation aborts everything; any partial block is discarded.
- States: FILL -> LAUNCH -> WAIT -> DRAIN -> FILL.
- FILL:
  - in_ready=1; a word is accepted on in_valid&&in_ready.
  - Word 0 -> block[127:96], 1 -> [95:64], 2 -> [63:32], 3 -> [31:0].
  - On word 0 acceptance, latch enc_dec and cbc_en.
  - iv_load with count=0 loads chain<=iv. If iv_load and in_valid coincide at count 0, iv loads first and that word uses the new chain.
  - iv_load at any other time is ignored.
  - On word 3 acceptance, register core_data_in:
    - encrypt+CBC: block^chain
    - otherwise: block
  - Then go to LAUNCH.
- LAUNCH: core_start=1 for exactly one cycle; core_enc_dec holds the latched mode; go to WAIT.
- WAIT:
  - in_ready=0. On first cycle with core_ready=1, capture result:
    - encrypt+CBC: res=core_data_out; chain<=core_data_out
    - decrypt+CBC: res=core_data_out^chain; chain<=core_data_in (received ciphertext)
    - ECB: res=core_data_out; chain unchanged
  - Go to DRAIN.
  - core_ready seen in the LAUNCH cycle itself is ignored.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES without core_ready: err<=1 (sticky until reset), discard block, go to FILL.
- DRAIN:
  - out_valid=1, out_data=res word idx (0=[127:96] first); idx advances on out_valid&&out_ready.
  - out_data holds stable while out_ready=0.
  - After word 3 is accepted: out_valid=0 next cycle, go to FILL, count=0.
- Latency: 4th input word accepted at cycle N -> core_start at N+1. Core ready at cycle M -> first out_valid at M+1.
- No overlap between blocks; in_ready=0 from LAUNCH through DRAIN.
- core_busy is not used for control.
- All XORs are 128-bit; no arithmetic.

Decomposition:
- Package xtea_pkg: state encoding (FILL, LAUNCH, WAIT, DRAIN), WORD_W=32, BLOCK_W=128, WORDS_PER_BLOCK=4.
- Single module; chaining logic is inline. No sub-module warranted.

Test Plan:
- Bench core model: ready 20 cycles after start, core_data_out = core_data_in ^ {4{32'hFFFFFFFF}}.
- ECB encrypt, words AAAABBBB, CCCCDDDD, AAAABBBB, CCCCDDDD:
  - core_start 1 cycle after 4th word; core_data_in=AAAABBBBCCCCDDDDAAAABBBBCCCCDDDD.
  - Outputs 55554444, 33332222, 55554444, 33332222.
- CBC encrypt, iv=DEADBEEF89ABCDEF01234567DEADBEEF, block of 4x00000000 then same again:
  - Block1 core_data_in=iv.
  - Block2 core_data_in = ~iv.
- CBC decrypt, same iv, block 4x00000000:
  - Output = 32'hFFFFFFFF^DEADBEEF = 21524110, then 76543210, FEDCBA98, 21524110.
  - chain=0 afterwards.
- Backpressure: hold out_ready=0 for 5 cycles during DRAIN -> out_data stable, no word lost, in_ready stays 0.
- Timeout (TIMEOUT_CYCLES=8), core never ready -> err=1 after 8 WAIT cycles, in_ready=1 next cycle; next block processes normally with err still 1.
- Reset asserted after word 2 -> next cycle count=0, in_ready=1, out_valid=0, chain=0; a fresh 4-word block produces correct output.
